match_reporter: RTL and testbench

MATCH_REPORTER -- requirements
Module: match_reporter

---
 rtl/match_reporter.sv | 140 ++++++++++++++
 tb/tb_match_reporter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_reporter.sv
// Match reporter: on a rising edge of match_in, captures three consecutive
// data words plus the frame id, then emits a four-word report (header and
// three data words) over a valid/ready stream. A match that arrives while a
// report is in progress is counted in a saturating drop counter.
module match_reporter (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        match_in,
    input  logic [31:0] data_in,
    input  logic [15:0] frame_id,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    output logic        tx_last,
    output logic        busy,
    output logic [7:0]  drop_count
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE1,
        CAPTURE2,
        SEND_HDR,
        SEND_D0,
        SEND_D1,
        SEND_D2
    } state_t;

    state_t      state;
    logic        match_q;
    logic [7:0]  seq;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [15:0] fid;
    logic        trigger;
    logic        xfer;

    // Trigger on the rising edge of the match flag; transfer on a valid/ready handshake
    always_comb begin
        trigger = match_in & ~match_q;
        xfer    = tx_valid & tx_ready;
    end

    // Report FSM with registered stream outputs, drop counter and sequence number
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            match_q    <= 1'b0;
            seq        <= '0;
            drop_count <= '0;
            w0         <= '0;
            w1         <= '0;
            w2         <= '0;
            fid        <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            tx_last    <= 1'b0;
            busy       <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            match_q    <= 1'b0;
            seq        <= '0;
            drop_count <= '0;
            w0         <= '0;
            w1         <= '0;
            w2         <= '0;
            fid        <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            tx_last    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            match_q <= match_in;

            if (trigger && (state != IDLE) && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        w0    <= data_in;
                        fid   <= frame_id;
                        busy  <= 1'b1;
                        state <= CAPTURE1;
                    end
                end
                CAPTURE1: begin
                    w1    <= data_in;
                    state <= CAPTURE2;
                end
                CAPTURE2: begin
                    w2       <= data_in;
                    tx_valid <= 1'b1;
                    tx_data  <= {8'hA5, seq, fid};
                    state    <= SEND_HDR;
                end
                SEND_HDR: begin
                    if (xfer) begin
                        tx_data <= w0;
                        state   <= SEND_D0;
                    end
                end
                SEND_D0: begin
                    if (xfer) begin
                        tx_data <= w1;
                        state   <= SEND_D1;
                    end
                end
                SEND_D1: begin
                    if (xfer) begin
                        tx_data <= w2;
                        tx_last <= 1'b1;
                        state   <= SEND_D2;
                    end
                end
                SEND_D2: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        tx_last  <= 1'b0;
                        busy     <= 1'b0;
                        seq      <= seq + 8'd1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    tx_data  <= '0;
                    tx_last  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_reporter.sv
// Testbench for match_reporter: table of report vectors plus hand-written
// sequences for drops, held match, clear, reset-with-match and seq wrap.
// Expected words are queued when a report is stimulated and checked as the
// DUT transfers them.
module tb_match_reporter;

    logic        clk;
    logic        n_rst;
    logic        clear;
    logic        match_in;
    logic [31:0] data_in;
    logic [15:0] frame_id;
    logic        tx_ready;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_last;
    logic        busy;
    logic [7:0]  drop_count;

    match_reporter dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .match_in  (match_in),
        .data_in   (data_in),
        .frame_id  (frame_id),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .busy      (busy),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] fid;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int unsigned stall;
        bit          drop;
    } vec_t;

    vec_t        vecs [6];
    logic [32:0] exp_q [$];
    logic [7:0]  seq_m;
    logic [7:0]  drop_m;
    int          tests;
    int          fails;
    int          words_seen;

    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard and hold-stability monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (n_rst) begin
            if (prev_stall) begin
                check("hold", {tx_valid, tx_last, tx_data}, {1'b1, prev_last, prev_data});
            end
            if (tx_valid && tx_ready) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {tx_last, tx_data}, 33'h0);
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h expected none", tx_data);
                end else begin
                    check("word", {tx_last, tx_data}, exp_q.pop_front());
                end
            end
            prev_stall = tx_valid && !tx_ready && !clear;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_report(input logic [15:0] fid, input logic [31:0] w0,
                               input logic [31:0] w1, input logic [31:0] w2);
        exp_q.push_back({1'b0, 8'hA5, seq_m, fid});
        exp_q.push_back({1'b0, w0});
        exp_q.push_back({1'b0, w1});
        exp_q.push_back({1'b1, w2});
        seq_m = seq_m + 8'd1;
    endtask

    // Drives a trigger now; returns 1ns into the SEND_HDR cycle (T+3)
    task automatic start_report(input logic [15:0] fid, input logic [31:0] w0,
                                input logic [31:0] w1, input logic [31:0] w2);
        push_report(fid, w0, w1, w2);
        match_in = 1'b1;
        frame_id = fid;
        data_in  = w0;
        @(posedge clk); #1;
        match_in = 1'b0;
        data_in  = w1;
        @(posedge clk); #1;
        data_in  = w2;
        @(posedge clk); #1;
        data_in  = $urandom;
        frame_id = $urandom;
    endtask

    // Returns on the falling edge of the first idle cycle
    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        start_report(v.fid, v.w0, v.w1, v.w2);
        if (v.stall > 0) begin
            @(posedge clk); #1;
            tx_ready = 1'b0;
            repeat (v.stall) @(posedge clk);
            #1;
            tx_ready = 1'b1;
        end else if (v.drop) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            match_in = 1'b1;
            @(posedge clk); #1;
            match_in = 1'b0;
            if (drop_m != 8'hFF) drop_m = drop_m + 8'd1;
        end else if (idx == 0) begin
            @(negedge clk);
            check("t3_valid_last", {31'h0, tx_valid, tx_last}, 33'h2);
            @(negedge clk);
            check("t4_last", {32'h0, tx_last}, 33'h0);
            @(negedge clk);
            check("t5_last", {32'h0, tx_last}, 33'h0);
            @(negedge clk);
            check("t6_last", {31'h0, tx_valid, tx_last}, 33'h3);
            @(negedge clk);
            check("t7_busy_valid", {31'h0, busy, tx_valid}, 33'h0);
        end
        wait_idle();
        check("drop_count", {25'h0, drop_count}, {25'h0, drop_m});
    endtask

    initial begin
        int base;
        tests      = 0;
        fails      = 0;
        words_seen = 0;
        seq_m      = '0;
        drop_m     = '0;
        prev_stall = 1'b0;
        n_rst      = 1'b0;
        clear      = 1'b0;
        match_in   = 1'b0;
        data_in    = '0;
        frame_id   = '0;
        tx_ready   = 1'b1;

        vecs[0] = '{16'h1234, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 0, 1'b0};
        vecs[1] = '{16'h1234, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 5, 1'b0};
        vecs[2] = '{16'hBEEF, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 0, 1'b1};
        vecs[3] = '{16'h0000, 32'h01020304, 32'h05060708, 32'h090A0B0C, 2, 1'b0};
        vecs[4] = '{16'hFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hA5A5A5A5, 0, 1'b0};
        vecs[5] = '{16'h4321, 32'h13579BDF, 32'h2468ACE0, 32'h0F0F0F0F, 1, 1'b0};

        // Reset state
        #2;
        check("rst_ctrl", {30'h0, tx_valid, tx_last, busy}, 33'h0);
        check("rst_data", {1'b0, tx_data}, 33'h0);
        check("rst_drop", {25'h0, drop_count}, 33'h0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Table-driven reports
        for (int i = 0; i < 6; i++) begin
            run_vec(i);
        end

        // Saturating drop counter: 300 drops while stalled in SEND_HDR
        start_report(16'h5555, 32'h01010101, 32'h02020202, 32'h03030303);
        tx_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            match_in = 1'b1;
            @(posedge clk); #1;
            match_in = 1'b0;
            if (drop_m != 8'hFF) drop_m = drop_m + 8'd1;
        end
        @(negedge clk);
        check("drop_sat", {25'h0, drop_count}, 33'hFF);
        check("stalled_valid", {31'h0, tx_valid, busy}, 33'h3);
        tx_ready = 1'b1;
        wait_idle();

        // Held match for 20 cycles yields exactly one report
        base = words_seen;
        push_report(16'h7777, 32'hCAFEF00D, 32'h0BADC0DE, 32'hFEEDFACE);
        match_in = 1'b1;
        frame_id = 16'h7777;
        data_in  = 32'hCAFEF00D;
        @(posedge clk); #1;
        data_in  = 32'h0BADC0DE;
        @(posedge clk); #1;
        data_in  = 32'hFEEDFACE;
        repeat (18) @(posedge clk);
        #1;
        match_in = 1'b0;
        repeat (10) @(negedge clk);
        check("held_words", words_seen - base, 33'd4);
        check("held_drop", {25'h0, drop_count}, {25'h0, drop_m});
        check("held_busy", {32'h0, busy}, 33'h0);

        // Clear during SEND_HDR with backpressure abandons the report
        @(negedge clk);
        start_report(16'h9999, 32'h11111111, 32'h22222222, 32'h33333333);
        tx_ready = 1'b0;
        clear    = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_q.delete();
        seq_m  = '0;
        drop_m = '0;
        @(negedge clk);
        check("clr_ctrl", {30'h0, tx_valid, tx_last, busy}, 33'h0);
        check("clr_drop", {25'h0, drop_count}, 33'h0);
        check("clr_data", {1'b0, tx_data}, 33'h0);
        tx_ready = 1'b1;
        start_report(16'hABCD, 32'h44444444, 32'h55555555, 32'h66666666);
        wait_idle();
        run_vec(2);

        // Async reset with match_in already high triggers on the first edge
        n_rst = 1'b0;
        #1;
        check("arst_ctrl", {30'h0, tx_valid, tx_last, busy}, 33'h0);
        check("arst_drop", {25'h0, drop_count}, 33'h0);
        exp_q.delete();
        seq_m  = '0;
        drop_m = '0;
        push_report(16'h0F0F, 32'h12345678, 32'h9ABCDEF0, 32'h0FEDCBA9);
        match_in = 1'b1;
        frame_id = 16'h0F0F;
        data_in  = 32'h12345678;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        match_in = 1'b0;
        data_in  = 32'h9ABCDEF0;
        @(posedge clk); #1;
        data_in  = 32'h0FEDCBA9;
        @(posedge clk); #1;
        wait_idle();

        // Back-to-back reports wrapping the sequence number
        for (int k = 0; k < 257; k++) begin
            start_report(16'(k), $urandom, $urandom, $urandom);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 33'(exp_q.size()), 33'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
